// File: rtl/mac_seq_pkg.sv
// ============================================================================
// mac_seq_pkg : shared types and defaults for the MAC dot-product sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package mac_seq_pkg;

   localparam int DEF_DATA_W         = 16;
   localparam int DEF_ACC_W          = 32;
   localparam int DEF_MAX_LEN        = 256;
   localparam int DEF_TIMEOUT_CYCLES = 64;

   typedef enum logic [1:0] {
      ST_ACCEPT = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } mac_seq_state_t;

   typedef struct packed {
      logic len_err;
      logic timeout;
   } mac_seq_status_t;

endpackage

`default_nettype wire

// File: rtl/mac_dot_sequencer_if.sv
// ============================================================================
// mac_dot_sequencer_if : element input, MAC issue/response and result buses
// Rev 1.0
// ============================================================================
`default_nettype none

interface mac_dot_sequencer_if
   import mac_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int LEN_W  = $clog2(DEF_MAX_LEN + 1)
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              in_last;
   logic [ACC_W-1:0]  cfg_bias;

   logic [DATA_W-1:0] mac_a;
   logic [DATA_W-1:0] mac_b;
   logic [ACC_W-1:0]  mac_c;
   logic              mac_valid;
   logic [ACC_W-1:0]  mac_result;
   logic              mac_ready;

   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_data;
   logic [LEN_W-1:0]  out_count;
   logic              out_len_err;
   logic              out_timeout;

   // Sequencer side
   modport slave (
      input  in_valid, in_a, in_b, in_last, cfg_bias,
      input  mac_result, mac_ready,
      input  out_ready,
      output in_ready,
      output mac_a, mac_b, mac_c, mac_valid,
      output out_valid, out_data, out_count, out_len_err, out_timeout
   );

   // Environment side (operand fetch, MAC datapath, result consumer)
   modport master (
      output in_valid, in_a, in_b, in_last, cfg_bias,
      output mac_result, mac_ready,
      output out_ready,
      input  in_ready,
      input  mac_a, mac_b, mac_c, mac_valid,
      input  out_valid, out_data, out_count, out_len_err, out_timeout
   );

endinterface

`default_nettype wire

// File: rtl/mac_seq_watchdog.sv
// ============================================================================
// mac_seq_watchdog : counts consecutive run cycles, flags expiry at the limit
// Rev 1.0
// ============================================================================
`default_nettype none

module mac_seq_watchdog
   import mac_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  wire clk,
   input  wire rst_n,
   input  wire run,
   output wire expire
);

   localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Dropping run clears the count, so each WAIT episode starts fresh
   always_comb begin
      cnt_d = '0;
      if (run) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = run && (cnt_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/mac_dot_sequencer.sv
// ============================================================================
// mac_dot_sequencer : issues one MAC per (a,b) element, chaining results into c
// Optional MAC watchdog enabled by defining MAC_SEQ_TIMEOUT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module mac_dot_sequencer
   import mac_seq_pkg::*;
#(
   parameter int DATA_W         = DEF_DATA_W,
   parameter int ACC_W          = DEF_ACC_W,
   parameter int MAX_LEN        = DEF_MAX_LEN,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input wire                 clk,
   input wire                 rst_n,
   mac_dot_sequencer_if.slave bus
);

   localparam int               LEN_W   = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

   mac_seq_state_t    state_q,    state_d;
   logic [DATA_W-1:0] a_q,        a_d;
   logic [DATA_W-1:0] b_q,        b_d;
   logic [ACC_W-1:0]  c_q,        c_d;
   logic              last_q,     last_d;
   logic [LEN_W-1:0]  count_q,    count_d;
   logic [ACC_W-1:0]  acc_q,      acc_d;
   mac_seq_status_t   status_q,   status_d;
   logic              in_ready_q, in_ready_d;

   logic in_hs;
   logic count_at_max;
   logic wdog_expire;

   assign in_hs        = (state_q == ST_ACCEPT) && in_ready_q && bus.in_valid;
   assign count_at_max = (count_q == MAX_CNT);

`ifdef MAC_SEQ_TIMEOUT_EN
   if (1) begin : g_watchdog
      mac_seq_watchdog #(
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_watchdog (
         .clk    (clk),
         .rst_n  (rst_n),
         .run    ((state_q == ST_WAIT) && !bus.mac_ready),
         .expire (wdog_expire)
      );
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign wdog_expire        = 1'b0;
`endif

   always_comb begin : p_next_state
      state_d = state_q;
      case (state_q)
         ST_ACCEPT: if (in_hs) state_d = ST_ISSUE;
         ST_ISSUE:  state_d = ST_WAIT;
         ST_WAIT: begin
            if (bus.mac_ready) begin
               state_d = (last_q || count_at_max) ? ST_DONE : ST_ACCEPT;
            end else if (wdog_expire) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE:   if (bus.out_ready) state_d = ST_ACCEPT;
         default:   state_d = ST_ACCEPT;
      endcase
   end

   always_comb begin : p_datapath
      a_d        = a_q;
      b_d        = b_q;
      c_d        = c_q;
      last_d     = last_q;
      count_d    = count_q;
      acc_d      = acc_q;
      status_d   = status_q;
      in_ready_d = (state_d == ST_ACCEPT);

      // Bias seeds c only on the first element; later elements chain the result
      if (in_hs) begin
         a_d     = bus.in_a;
         b_d     = bus.in_b;
         last_d  = bus.in_last;
         count_d = count_q + 1'b1;
         c_d     = (count_q == '0) ? bus.cfg_bias : acc_q;
      end

      if (state_q == ST_WAIT) begin
         if (bus.mac_ready) begin
            acc_d            = bus.mac_result;
            status_d.len_err = count_at_max && !last_q;
         end else if (wdog_expire) begin
            status_d.timeout = 1'b1;
         end
      end

      if ((state_q == ST_DONE) && bus.out_ready) begin
         count_d  = '0;
         acc_d    = '0;
         status_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_ACCEPT;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         last_q     <= 1'b0;
         count_q    <= '0;
         acc_q      <= '0;
         status_q   <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         c_q        <= c_d;
         last_q     <= last_d;
         count_q    <= count_d;
         acc_q      <= acc_d;
         status_q   <= status_d;
         in_ready_q <= in_ready_d;
      end
   end

   always_comb begin : p_outputs
      bus.in_ready    = in_ready_q;
      bus.mac_valid   = (state_q == ST_ISSUE);
      bus.mac_a       = a_q;
      bus.mac_b       = b_q;
      bus.mac_c       = c_q;
      bus.out_valid   = (state_q == ST_DONE);
      bus.out_data    = acc_q;
      bus.out_count   = count_q;
      bus.out_len_err = status_q.len_err;
      bus.out_timeout = status_q.timeout;
   end

endmodule

`default_nettype wire

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
- Upstream operand sequencer for the single-cycle MAC unit (result = a*b + c, registered, ready pulse one cycle after valid).
- Accepts a stream of (a, b) element pairs plus a per-vector bias, and issues one MAC operation per element.
- Feeds each MAC result back as the next c, and emits the final dot-product-plus-bias on a valid/ready output.
- Sits between the operand fetch/DMA path and the MAC datapath in the accelerator tile.

Parameters:
DATA_W, 16, operand width of a and b
ACC_W, 32, accumulator/result width; must be ≥ 2*DATA_W
MAX_LEN, 256, maximum elements per vector before forced termination
LEN_W, $clog2(MAX_LEN+1), element counter width (derived, localparam)
TIMEOUT_CYCLES, 64, MAC response watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  element valid
in_ready  out  1  element accepted when in_valid && in_ready
in_a  in  DATA_W  operand a
in_b  in  DATA_W  operand b
in_last  in  1  marks final element of vector
cfg_bias  in  ACC_W  bias; sampled with the first element of each vector
mac_a  out  DATA_W  to MAC a
mac_b  out  DATA_W  to MAC b
mac_c  out  ACC_W  to MAC c
mac_valid  out  1  one-cycle MAC issue strobe
mac_result  in  ACC_W  from MAC result
mac_ready  in  1  MAC completion pulse
out_valid  out  1  dot product available
out_ready  in  1  consumer accepts when out_valid && out_ready
out_data  out  ACC_W  final accumulated value
out_count  out  LEN_W  number of elements consumed for this vector
out_len_err  out  1  vector hit MAX_LEN without in_last
out_timeout  out  1  MAC failed to respond (always 0 without macro)

Behaviour:
- Reset: all outputs 0, including in_ready, mac_*, out_*. Accumulator and counter are 0. State is ACCEPT.
- FSM states: ACCEPT, ISSUE, WAIT, DONE.
- ACCEPT:
  - in_ready=1.
  - On handshake, latch a, b and last; count++.
  - If count was 0, c_sel=cfg_bias, else c_sel=acc.
  - Go to ISSUE.
- ISSUE:
  - mac_valid=1 for exactly this cycle, with mac_a/mac_b/mac_c = latched values.
  - Go to WAIT.
  - mac_a/b/c hold their values until the next ISSUE.
- WAIT:
  - mac_valid=0, in_ready=0.
  - On mac_ready: acc <= mac_result.
  - If last, or count==MAX_LEN: go to DONE, and set out_len_err = (count==MAX_LEN && !last).
  - Otherwise return to ACCEPT.
- DONE:
  - out_valid=1; out_data=acc; out_count=count. All held stable until out_ready.
  - On handshake: clear count, acc, out_valid and error flags; go to ACCEPT.
- Throughput: 1 element per 3 cycles with a 1-cycle MAC. Input-to-result latency: last-element handshake at T → out_valid at T+3.
- mac_ready outside WAIT is ignored; no state change.
- in_valid is ignored in ISSUE/WAIT/DONE (in_ready=0).
- Arithmetic: the block adds nothing itself; MAC wrap modulo 2^ACC_W passes through unchanged.
- MAX_LEN boundary: the MAX_LEN-th element with in_last=1 completes normally, out_len_err=0.
- Reset mid-operation (any state): immediate return to reset values. A MAC response arriving afterwards is ignored.
- cfg_bias changes after the first element of a vector have no effect on that vector.

Optional Feature:
- Macro: MAC_SEQ_TIMEOUT_EN.
- When defined:
  - A watchdog counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles pass without mac_ready, go to DONE with out_timeout=1, out_data=current acc, out_count=count.
  - A late mac_ready after the timeout is ignored.
- When undefined: no counter; WAIT holds indefinitely; out_timeout tied to 0.

Decomposition:
- Package mac_seq_pkg:
  - state enum (ACCEPT, ISSUE, WAIT, DONE)
  - default DATA_W/ACC_W localparams
  - result-status struct (len_err, timeout)
- Sub-module mac_seq_watchdog (load/clear/expire counter), instantiated only under MAC_SEQ_TIMEOUT_EN.

Test Plan:
- Bias 4, elements (2,3),(5,7,last) → one 1-cycle mac_valid per element; mac_c=4 then 10; out_data=45, out_count=2, flags 0.
- Bias 50, single element (0,100,last) → out_data=50, out_count=1, out_valid at 3 cycles after handshake.
- Out_ready low for 5 cycles in DONE → out_valid/out_data=45 stable, in_ready=0; accepted on cycle out_ready rises; next vector restarts with new bias.
- MAX_LEN=4, five elements (1,1) none last, bias 0 → out_data=4, out_count=4, out_len_err=1; fifth element accepted as first of next vector.
- rst_n low during WAIT, stray mac_ready after release → all outputs 0; no acc update; next vector correct (bias 4, (2,3,last) → 10).
- With MAC_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, MAC stub never responds → out_timeout=1 after 8 WAIT cycles, out_count=1; without macro, no out_valid after 100 cycles.
